// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, single-outstanding imem handshake,
// one-entry skid buffer for responses that arrive under hold, and the IF/DEC register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        hold_i,
  input  logic        bypass_i,
  input  logic        branch_i,
  input  logic [31:0] PCnext_i,
  input  logic [31:0] PCcurrent_i,
  output logic        imemReq_o,
  output logic [31:0] imemAddr_o,
  input  logic        imemGnt_i,
  input  logic        imemRvalid_i,
  input  logic [31:0] imemRdata_i,
  output logic [31:0] PCIF_o,
  output logic [31:0] instrDEC_o,
  output logic        validDEC_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HELD,
    S_DISCARD
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pcif_q, pcif_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic [31:0] skid_q, skid_d;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_inc;
  logic        load_word;
  logic [31:0] load_data;

  always_comb begin
    redirect  = flush_i | branch_i | bypass_i;
    target    = bypass_i ? {PCnext_i[31:1], 1'b0}
              : (branch_i ? PCcurrent_i + PCnext_i : PCnext_i);
    pc_inc    = pc_q + 32'd4;
    state_d   = state_q;
    pc_d      = pc_q;
    skid_d    = skid_q;
    load_word = 1'b0;
    load_data = imemRdata_i;

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (redirect) begin
          pc_d    = target;
          state_d = imemGnt_i ? S_DISCARD : S_REQ;
        end else if (imemGnt_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          pc_d    = target;
          state_d = imemRvalid_i ? S_REQ : S_DISCARD;
        end else if (imemRvalid_i) begin
          if (hold_i) begin
            skid_d  = imemRdata_i;
            state_d = S_HELD;
          end else begin
            load_word = 1'b1;
            pc_d      = pc_inc;
            state_d   = S_REQ;
          end
        end
      end
      S_HELD: begin
        if (redirect) begin
          skid_d  = NOP_INSTR;
          pc_d    = target;
          state_d = S_REQ;
        end else if (!hold_i) begin
          load_word = 1'b1;
          load_data = skid_q;
          skid_d    = NOP_INSTR;
          pc_d      = pc_inc;
          state_d   = S_REQ;
        end
      end
      S_DISCARD: begin
        // A redirect here retargets the PC; the stale response still has to be
        // drained before a new request can go out.
        if (redirect) pc_d = target;
        if (imemRvalid_i) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pcif_d  = pcif_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (redirect) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (!hold_i) begin
      if (load_word) begin
        pcif_d  = pc_q;
        instr_d = load_data;
        valid_d = 1'b1;
      end else begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      pcif_q  <= RESET_PC;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      skid_q  <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pcif_q  <= pcif_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      skid_q  <= skid_d;
    end
  end

  assign imemReq_o  = (state_q == S_REQ);
  assign imemAddr_o = pc_q;
  assign PCIF_o     = pcif_q;
  assign instrDEC_o = instr_q;
  assign validDEC_o = valid_q;

endmodule
